// File: rtl/vending_pkg.sv
// Shared vending constants: coin channels, coin values and the acceptor FSM encoding.
// Also holds the value lookup and saturating add used by coin_acceptor.
package vending_pkg;

  localparam int NUM_CH  = 3;
  localparam int CH_ONE  = 0;
  localparam int CH_TWO  = 1;
  localparam int CH_FIVE = 2;

  localparam logic [7:0] VAL_ONE  = 8'd1;
  localparam logic [7:0] VAL_TWO  = 8'd2;
  localparam logic [7:0] VAL_FIVE = 8'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCEPT  = 2'd1,
    ST_LOCKOUT = 2'd2
  } fsm_state_t;

  function automatic logic [7:0] coin_value(input logic [NUM_CH-1:0] sel);
    logic [7:0] v;
    v = 8'd0;
    if (sel[CH_ONE])  v = VAL_ONE;
    if (sel[CH_TWO])  v = VAL_TWO;
    if (sel[CH_FIVE]) v = VAL_FIVE;
    return v;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor channel: 2-flop synchronizer, counting debouncer and a
// registered single-cycle pulse on each debounced 0->1 transition.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_q;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_rise    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the current level restarts the run.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_TC) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_level_q <= r_level;
      r_rise    <= r_level & ~r_level_q;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces three coin sensors, accepts or rejects each coin
// event, and keeps a saturating running total of accepted value.
//   state   | meaning
//   IDLE    | waiting for a coin event
//   ACCEPT  | one-cycle value strobe, total updated
//   LOCKOUT | fixed dead time; any event here is rejected
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_coin_raw,
  input  logic       i_enable,
  input  logic       i_clear,
  output logic       o_one_cny,
  output logic       o_two_cny,
  output logic       o_five_cny,
  output logic       o_reject,
  output logic       o_busy,
  output logic [7:0] o_total_cny
);

  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

  logic [NUM_CH-1:0] w_rise;
  logic              w_any_evt;
  logic              w_multi_evt;

  fsm_state_t        r_state,    w_state_nxt;
  logic [LW-1:0]     r_lock_cnt, w_lock_cnt_nxt;
  logic [NUM_CH-1:0] r_coin_sel, w_coin_sel_nxt;
  logic              r_rej_pend, w_rej_pend_nxt;
  logic [7:0]        r_total;

  logic [NUM_CH-1:0] w_strobe;
  logic              w_reject;
  logic              w_add;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (i_coin_raw[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_any_evt   = |w_rise;
  assign w_multi_evt = w_any_evt && !$onehot(w_rise);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lock_cnt <= '0;
      r_coin_sel <= '0;
      r_rej_pend <= 1'b0;
      r_total    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_coin_sel <= w_coin_sel_nxt;
      r_rej_pend <= w_rej_pend_nxt;
      if (i_clear) begin
        r_total <= '0;
      end else if (w_add) begin
        r_total <= sat_add8(r_total, coin_value(r_coin_sel));
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_coin_sel_nxt = r_coin_sel;
    w_rej_pend_nxt = 1'b0;
    w_strobe       = '0;
    w_reject       = 1'b0;
    w_add          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_evt) begin
          if (i_enable && !w_multi_evt) begin
            w_state_nxt    = ST_ACCEPT;
            w_coin_sel_nxt = w_rise;
          end else begin
            w_reject       = 1'b1;
            w_state_nxt    = ST_LOCKOUT;
            w_lock_cnt_nxt = LOCK_LOAD;
          end
        end
      end
      ST_ACCEPT: begin
        w_strobe       = r_coin_sel;
        w_add          = 1'b1;
        // A coin landing during the value strobe is rejected one cycle later
        // so a value strobe and o_reject never coincide.
        w_rej_pend_nxt = w_any_evt;
        w_state_nxt    = ST_LOCKOUT;
        w_lock_cnt_nxt = LOCK_LOAD;
      end
      ST_LOCKOUT: begin
        w_reject = w_any_evt | r_rej_pend;
        if (r_lock_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_one_cny   = w_strobe[CH_ONE];
  assign o_two_cny   = w_strobe[CH_TWO];
  assign o_five_cny  = w_strobe[CH_FIVE];
  assign o_reject    = w_reject;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_total_cny = r_total;

endmodule
